// File: rtl/freq_div_led_chaser.sv
// freq_div_led_chaser: prescaled, divided timebase driving a one-hot LED
// running light with rotate-left, rotate-right, bounce and hold patterns.
// The divisor is pipelined once and only reloaded at a step boundary, or
// while the divider is stopped, so a divisor change never distorts the
// period in progress.
module freq_div_led_chaser #(
    parameter int LED_N    = 8,
    parameter int DIV_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DIV_W-1:0] datain,
    input  logic [1:0]       mode,
    output logic [LED_N-1:0] diode,
    output logic             step_pulse
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [LED_N-1:0] LED_HOME = LED_N'(1);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // True when exactly one bit of the LED vector is set.
    function automatic logic is_onehot(input logic [LED_N-1:0] v);
        return (v != {LED_N{1'b0}}) && ((v & (v - LED_HOME)) == {LED_N{1'b0}});
    endfunction

    logic [DIV_W-1:0] din_q,     din_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [LED_N-1:0] diode_q,   diode_d;
    logic             step_q,    step_d;
    dir_e             dir_q,     dir_d;

    logic             div_run_s;
    logic             pre_tick_s;
    logic             step_s;
    logic [LED_N-1:0] rol_s;
    logic [LED_N-1:0] ror_s;

    assign rol_s = {diode_q[LED_N-2:0], diode_q[LED_N-1]};
    assign ror_s = {diode_q[0], diode_q[LED_N-1:1]};

    // Timebase: prescaler, divider, step strobe and divisor reload.
    always_comb begin
        din_d      = datain;
        div_run_s  = (div_act_q != {DIV_W{1'b0}});
        pre_tick_s = div_run_s && (pre_cnt_q == PRE_LAST);
        step_s     = pre_tick_s && (div_cnt_q == (div_act_q - DIV_ONE));
        step_d     = step_s;

        if (!div_run_s) begin
            pre_cnt_d = {PRE_W{1'b0}};
        end else if (pre_tick_s) begin
            pre_cnt_d = {PRE_W{1'b0}};
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_ONE;
        end

        if (!div_run_s) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else if (step_s) begin
            div_cnt_d = {DIV_W{1'b0}};
        end else if (pre_tick_s) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
        end else begin
            div_cnt_d = div_cnt_q;
        end

        // Reload only at a period boundary or while stopped.
        if (step_s || !div_run_s) begin
            div_act_d = din_q;
        end else begin
            div_act_d = div_act_q;
        end
    end

    // Pattern engine: next LED position and bounce direction on each step.
    always_comb begin
        diode_d = diode_q;
        dir_d   = dir_q;
        if (!is_onehot(diode_q)) begin
            // Corrupted pattern recovers to the reset position.
            diode_d = LED_HOME;
            dir_d   = DIR_LEFT;
        end else if (step_s) begin
            case (mode)
                2'b00: begin
                    diode_d = rol_s;
                    dir_d   = DIR_LEFT;
                end
                2'b01: begin
                    diode_d = ror_s;
                    dir_d   = DIR_RIGHT;
                end
                2'b10: begin
                    if (dir_q == DIR_LEFT) begin
                        if (diode_q[LED_N-1]) begin
                            diode_d = ror_s;
                            dir_d   = DIR_RIGHT;
                        end else begin
                            diode_d = rol_s;
                        end
                    end else begin
                        if (diode_q[0]) begin
                            diode_d = rol_s;
                            dir_d   = DIR_LEFT;
                        end else begin
                            diode_d = ror_s;
                        end
                    end
                end
                2'b11: begin
                    diode_d = diode_q;
                end
                default: begin
                    diode_d = diode_q;
                    dir_d   = dir_q;
                end
            endcase
        end else begin
            diode_d = diode_q;
            dir_d   = dir_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            din_q     <= {DIV_W{1'b0}};
            div_act_q <= {DIV_W{1'b0}};
            pre_cnt_q <= {PRE_W{1'b0}};
            div_cnt_q <= {DIV_W{1'b0}};
            diode_q   <= LED_HOME;
            step_q    <= 1'b0;
            dir_q     <= DIR_LEFT;
        end else begin
            din_q     <= din_d;
            div_act_q <= div_act_d;
            pre_cnt_q <= pre_cnt_d;
            div_cnt_q <= div_cnt_d;
            diode_q   <= diode_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
        end
    end

    assign diode      = diode_q;
    assign step_pulse = step_q;

endmodule
